// File: rtl/reg_bank_pkg.sv
// Shared constants and elaboration helpers for the 2-read/1-write register bank.
package reg_bank_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_NREG   = 8;
   localparam int DEF_ADDR_W = 3;

   // The PC always occupies the highest register index.
   function automatic int pc_idx(input int nreg);
      return nreg - 1;
   endfunction

   function automatic int addr_bits(input int n);
      int b;
      b = 0;
      while ((1 << b) < n) b++;
      return b;
   endfunction

endpackage

// File: rtl/reg_bank_2r1w_if.sv
// Control/data bundle between the control unit (master) and the register bank (slave).
interface reg_bank_2r1w_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              pc_inc;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              rd_valid;
   logic [DATA_W-1:0] pc_out;

   modport master (
      output wr_en, wr_addr, wr_data, pc_inc, rd_en, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, rd_valid, pc_out
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, pc_inc, rd_en, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, rd_valid, pc_out
   );
endinterface

// File: rtl/reg_bank_read_port.sv
// One registered read port: index mux with out-of-range zero, optional write-through.
// Write-through forwarding is enabled by defining REG_BANK_WR_BYPASS_EN.
module reg_bank_read_port
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREG   = DEF_NREG,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        rd_en,
   input  logic [ADDR_W-1:0]           rd_addr,
   input  logic [NREG-1:0][DATA_W-1:0] regs,
   input  logic                        wr_en,
   input  logic [ADDR_W-1:0]           wr_addr,
   input  logic [DATA_W-1:0]           wr_data,
   output logic [DATA_W-1:0]           rd_data
);

   logic [DATA_W-1:0] sel;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;

   // Equality decode only matches in-range indices, so out-of-range reads fall through to 0.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NREG; i++)
         if (rd_addr == ADDR_W'(i)) sel = regs[i];
`ifdef REG_BANK_WR_BYPASS_EN
      for (int i = 0; i < NREG; i++)
         if (wr_en && wr_addr == ADDR_W'(i) && rd_addr == ADDR_W'(i)) sel = wr_data;
`endif
      rd_data_d = rd_en ? sel : rd_data_q;
   end

`ifndef REG_BANK_WR_BYPASS_EN
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rd_data_q <= '0;
      else       rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/reg_bank_2r1w.sv
// NREG x DATA_W register bank, top index is an auto-incrementing PC; two registered read ports.
// Optional write-through forwarding on reads: define REG_BANK_WR_BYPASS_EN.
module reg_bank_2r1w
   import reg_bank_pkg::*;
#(
   parameter int              DATA_W   = DEF_DATA_W,
   parameter int              NREG     = DEF_NREG,
   parameter int              ADDR_W   = DEF_ADDR_W,
   parameter logic [DATA_W-1:0] PC_RESET = '0
) (
   input logic            clock,
   input logic            reset,
   reg_bank_2r1w_if.slave bus
);

   localparam int PC_I = pc_idx(NREG);

   generate
      if (NREG < 2 || NREG > 256 || ADDR_W < addr_bits(NREG)) begin : g_bad_cfg
         $error("reg_bank_2r1w: illegal NREG/ADDR_W combination");
      end
   endgenerate

   logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
   logic                        rd_valid_q, rd_valid_d;
   logic                        pc_written;

   // An explicit write to the PC outranks the increment.
   always_comb begin
      regs_d     = regs_q;
      pc_written = bus.wr_en && (bus.wr_addr == ADDR_W'(PC_I));
      if (bus.wr_en)
         for (int i = 0; i < NREG; i++)
            if (bus.wr_addr == ADDR_W'(i)) regs_d[i] = bus.wr_data;
      if (bus.pc_inc && !pc_written)
         regs_d[PC_I] = regs_q[PC_I] + DATA_W'(1);
      rd_valid_d = bus.rd_en;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         regs_q       <= '0;
         regs_q[PC_I] <= PC_RESET;
         rd_valid_q   <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   reg_bank_read_port #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) u_port_a (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (bus.rd_en),
      .rd_addr (bus.rd_addr_a),
      .regs    (regs_q),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_data (bus.rd_data_a)
   );

   reg_bank_read_port #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) u_port_b (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (bus.rd_en),
      .rd_addr (bus.rd_addr_b),
      .regs    (regs_q),
      .wr_en   (bus.wr_en),
      .wr_addr (bus.wr_addr),
      .wr_data (bus.wr_data),
      .rd_data (bus.rd_data_b)
   );

   assign bus.rd_valid = rd_valid_q;
   assign bus.pc_out   = regs_q[PC_I];

endmodule

// File: tb/tb_reg_bank_2r1w.sv
// Directed bench: default 8-register bank via a vector table, plus reset and NREG=6 sequences.
module tb_reg_bank_2r1w;

`ifdef REG_BANK_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   reg_bank_2r1w_if #(.DATA_W(16), .ADDR_W(3)) if1 ();
   reg_bank_2r1w_if #(.DATA_W(16), .ADDR_W(3)) if2 ();

   reg_bank_2r1w #(.DATA_W(16), .NREG(8), .ADDR_W(3), .PC_RESET(16'h0000)) dut8 (
      .clock (clock), .reset (reset), .bus (if1.slave));
   reg_bank_2r1w #(.DATA_W(16), .NREG(6), .ADDR_W(3), .PC_RESET(16'h0000)) dut6 (
      .clock (clock), .reset (reset), .bus (if2.slave));

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic        inc;
      logic        re;
      logic [2:0]  ra;
      logic [2:0]  rb;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        ev;
      logic [15:0] epc;
   } vec_t;

   vec_t vecs[12];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive1(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic inc, input logic re, input logic [2:0] ra, input logic [2:0] rb);
      if1.wr_en = we; if1.wr_addr = wa; if1.wr_data = wd; if1.pc_inc = inc;
      if1.rd_en = re; if1.rd_addr_a = ra; if1.rd_addr_b = rb;
   endtask

   task automatic drive2(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic inc, input logic re, input logic [2:0] ra, input logic [2:0] rb);
      if2.wr_en = we; if2.wr_addr = wa; if2.wr_data = wd; if2.pc_inc = inc;
      if2.rd_en = re; if2.rd_addr_a = ra; if2.rd_addr_b = rb;
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      //             we wa  wd        inc re ra  rb  ea                          eb        ev epc
      vecs[0]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd0, 3'd7, 16'h0000, 16'h0000, 1'b1, 16'h0000};
      vecs[1]  = '{1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd3, 3'd3, 16'h1234, 16'h1234, 1'b1, 16'h0000};
      vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[4]  = '{1'b1, 3'd5, 16'h0001, 1'b0, 1'b0, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 16'h0000};
      vecs[5]  = '{1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1, 3'd5, 3'd3,
                   BYP ? 16'hBEEF : 16'h0001, 16'h1234, 1'b1, 16'h0000};
      vecs[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 3'd0, 16'hBEEF, 16'h0000, 1'b1, 16'h0000};
      vecs[7]  = '{1'b1, 3'd7, 16'hFFFF, 1'b0, 1'b0, 3'd0, 3'd0, 16'hBEEF, 16'h0000, 1'b0, 16'hFFFF};
      vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000};
      vecs[9]  = '{1'b1, 3'd7, 16'h0040, 1'b1, 1'b0, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0040};
      vecs[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd7, 3'd1, 16'h0040, 16'h0000, 1'b1, 16'h0041};
      vecs[11] = '{1'b1, 3'd7, 16'h1000, 1'b0, 1'b1, 3'd7, 3'd6,
                   BYP ? 16'h1000 : 16'h0041, 16'h0000, 1'b1, 16'h1000};

      drive1(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0);
      drive2(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0);
      repeat (2) @(negedge clock);
      chk("rst_rd_a", if1.rd_data_a, 16'h0000);
      chk("rst_rd_b", if1.rd_data_b, 16'h0000);
      chk("rst_valid", {15'd0, if1.rd_valid}, 16'h0000);
      chk("rst_pc", if1.pc_out, 16'h0000);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         drive1(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].inc, vecs[i].re, vecs[i].ra, vecs[i].rb);
         step();
         chk($sformatf("v%0d_rd_a", i), if1.rd_data_a, vecs[i].ea);
         chk($sformatf("v%0d_rd_b", i), if1.rd_data_b, vecs[i].eb);
         chk($sformatf("v%0d_valid", i), {15'd0, if1.rd_valid}, {15'd0, vecs[i].ev});
         chk($sformatf("v%0d_pc", i), if1.pc_out, vecs[i].epc);
      end

      // Reset lands between launch and edge: pending read and write are dropped.
      drive1(1'b1, 3'd2, 16'h5555, 1'b1, 1'b1, 3'd2, 3'd2);
      #2 reset = 1'b1;
      #1;
      chk("midrst_rd_a", if1.rd_data_a, 16'h0000);
      chk("midrst_rd_b", if1.rd_data_b, 16'h0000);
      chk("midrst_valid", {15'd0, if1.rd_valid}, 16'h0000);
      chk("midrst_pc", if1.pc_out, 16'h0000);
      step();
      chk("midrst_valid_edge", {15'd0, if1.rd_valid}, 16'h0000);
      reset = 1'b0;
      drive1(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd2, 3'd3);
      step();
      chk("postrst_r2", if1.rd_data_a, 16'h0000);
      chk("postrst_r3", if1.rd_data_b, 16'h0000);
      chk("postrst_valid", {15'd0, if1.rd_valid}, 16'h0001);
      drive1(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0);

      // NREG=6: PC is index 5, indices 6 and 7 are out of range.
      drive2(1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 3'd0, 3'd0);
      step();
      step();
      chk("n6_pc_inc2", if2.pc_out, 16'h0002);
      drive2(1'b1, 3'd6, 16'hAAAA, 1'b0, 1'b0, 3'd0, 3'd0);
      step();
      chk("n6_pc_after_oor_wr", if2.pc_out, 16'h0002);
      drive2(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd6, 3'd5);
      step();
      chk("n6_rd_idx6", if2.rd_data_a, 16'h0000);
      chk("n6_rd_pc", if2.rd_data_b, 16'h0002);
      chk("n6_valid", {15'd0, if2.rd_valid}, 16'h0001);
      drive2(1'b1, 3'd7, 16'h5555, 1'b0, 1'b0, 3'd0, 3'd0);
      step();
      drive2(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd0, 3'd4);
      step();
      chk("n6_r0", if2.rd_data_a, 16'h0000);
      chk("n6_r4", if2.rd_data_b, 16'h0000);
      drive2(1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 3'd7, 3'd5);
      step();
      chk("n6_rd_idx7", if2.rd_data_a, 16'h0000);
      chk("n6_pc_final", if2.rd_data_b, 16'h0002);
      drive2(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 3'd0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_bank_2r1w.md
Name: reg_bank_2r1w

Overview:
- Parametrised register bank: NREG general registers of DATA_W bits, the top index hardwired as the program counter (PC).
- Two independent registered read ports, one write port, and PC auto-increment.
- Next-generation replacement for the single-port combinational register-bank read multiplexer.
- Sits between the control unit (addresses, enables) and the datapath ALU/bus.

Parameters:
- DATA_W, 16, width of every register and data port.
- NREG, 8, number of registers including PC; legal range 2..256; index NREG-1 is PC.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= NREG.
- PC_RESET, 0, PC value loaded on reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write register index.
- wr_data  in  DATA_W  write data.
- pc_inc  in  1  increment PC by 1 this cycle.
- rd_en  in  1  launch a read on both ports.
- rd_addr_a  in  ADDR_W  port A read index.
- rd_addr_b  in  ADDR_W  port B read index.
- rd_data_a  out  DATA_W  port A registered read data.
- rd_data_b  out  DATA_W  port B registered read data.
- rd_valid  out  1  rd_data_a/b hold the result of the read launched on the previous cycle.
- pc_out  out  DATA_W  current PC, direct from the PC register.

Behaviour:
- Reset (async, active-high):
  - Registers 0..NREG-2 clear to 0; PC loads PC_RESET.
  - rd_data_a and rd_data_b clear to 0; rd_valid clears to 0.
  - Reset asserted mid-operation discards any pending read and any write in that cycle.
- Write: on the clock edge with wr_en=1 and wr_addr<NREG, reg[wr_addr] <= wr_data.
  - wr_addr>=NREG: write ignored.
- PC update priority, evaluated on each edge:
  1. wr_en with wr_addr=NREG-1 loads wr_data.
  2. Otherwise pc_inc loads PC+1, modulo 2**DATA_W (all-ones wraps to 0).
  3. Otherwise PC holds.
- Read latency is 1 cycle:
  - rd_en=1 at edge N: rd_data_a/b take reg[rd_addr_a/b] at edge N and rd_valid=1 after edge N.
  - rd_en=0: rd_data_a/b hold their previous values and rd_valid=0.
- Read address >= NREG returns 0.
- Read sees pre-edge state: a read and a write (or pc_inc) to the same index in the same cycle return the old value, unless the optional bypass feature is enabled.
- Both ports may address the same register; both return identical data.
- pc_out is combinational from the PC register (0-cycle latency) and is always valid after reset.
- No back-pressure: one read may be launched every cycle, so throughput is 1 read pair per cycle.

Optional Feature:
- Macro: REG_BANK_WR_BYPASS_EN.
- Defined: a read port whose index equals wr_addr with wr_en=1 in the same cycle captures wr_data (write-through forwarding).
  - pc_inc alone is never forwarded; a read of PC still returns the pre-increment value.
- Undefined: old-value read semantics as stated in Behaviour.

Decomposition:
- Package reg_bank_pkg:
  - default DATA_W/NREG/ADDR_W constants;
  - PC_IDX function (NREG-1);
  - a clog2-style helper for ADDR_W checks.
- One sub-module, reg_bank_read_port:
  - index-to-data mux, range check returning 0, optional bypass compare, output register;
  - instantiated twice (ports A and B).
- Storage, write decode and PC logic live in the top module.

Test Plan:
- Reset with defaults -> all rd_data 0, rd_valid 0, pc_out 0x0000. Then rd_en with A=0, B=7 -> next cycle rd_data_a=0, rd_data_b=0, rd_valid=1.
- Write 0x1234 to r3, then read A=3, B=3 -> one cycle after rd_en: both 0x1234, rd_valid=1. Next cycle with rd_en=0 -> data held, rd_valid=0.
- Same cycle: write 0xBEEF to r5 and read A=5 (r5 previously 0x0001) -> rd_data_a=0x0001 without macro; 0xBEEF with REG_BANK_WR_BYPASS_EN.
- PC=0xFFFF, pc_inc=1 -> pc_out=0x0000. Same cycle: wr_en to r7 with 0x0040 and pc_inc=1 -> pc_out=0x0040 (write wins).
- NREG=6, ADDR_W=3: write 0xAAAA to index 6, then read index 6 and index 5 -> 0 and PC value respectively; no register changed.
- Issue rd_en and assert reset mid-cycle before the edge -> rd_valid stays 0, rd_data 0, PC=PC_RESET immediately (async).
